// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index, data word and hazard controller state.
// Also holds the saturating increment used by the hazard perf counters.
package cpu_types_pkg;

  typedef logic [4:0]  regbits_t;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    HALT    = 2'd2
  } hazstate_t;

  localparam word_t WORD_MAX = 32'hFFFF_FFFF;

  function automatic word_t sat_inc(input word_t v, input logic en);
    if (en && (v != WORD_MAX)) return v + 32'd1;
    return v;
  endfunction

endpackage

// File: rtl/hazard_perf.sv
// Three saturating event counters for the hazard controller
// (load-use bubbles, dmem freeze cycles, taken-branch flushes).
module hazard_perf
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  nRST,
  input  logic  ld_inc,
  input  logic  mem_inc,
  input  logic  flush_inc,
  output word_t ld_cnt,
  output word_t mem_cnt,
  output word_t flush_cnt
);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ld_cnt    <= '0;
      mem_cnt   <= '0;
      flush_cnt <= '0;
    end else begin
      ld_cnt    <= sat_inc(ld_cnt, ld_inc);
      mem_cnt   <= sat_inc(mem_cnt, mem_inc);
      flush_cnt <= sat_inc(flush_cnt, flush_inc);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: drives PC and pipeline-register write/flush.
// Define HAZARD_PERF_EN to build the performance counter bank.
//
// state   | meaning
// RUN     | normal flow, load-use detection active
// LDSTALL | one bubble just inserted, load-use detection masked
// HALT    | terminal freeze, left only through nRST
module hazard_ctrl
  import cpu_types_pkg::*;
(
  input  logic     CLK,
  input  logic     nRST,
  input  logic     ihit,
  input  logic     dhit,
  input  logic     memREQ,
  input  logic     memHALT,
  input  logic     brTaken,
  input  logic     exMemRead,
  input  regbits_t exrt,
  input  regbits_t idrsel1,
  input  regbits_t idrsel2,
  output logic     pcW,
  output logic     ifidW,
  output logic     ifidRST,
  output logic     idexW,
  output logic     idexRST,
  output logic     exmemW,
  output logic     exmemRST,
  output logic     memwbW,
  output logic     memwbRST,
  output logic     halted,
  output word_t    ldStallCnt,
  output word_t    memStallCnt,
  output word_t    flushCnt
);

  hazstate_t state, state_nxt;
  logic      dmem_wait, ld_use;

  assign dmem_wait = memREQ && !dhit;
  assign ld_use    = (state == RUN) && exMemRead && (exrt != '0) &&
                     ((exrt == idrsel1) || (exrt == idrsel2));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    pcW       = 1'b1;
    ifidW     = 1'b1;
    idexW     = 1'b1;
    exmemW    = 1'b1;
    memwbW    = 1'b1;
    ifidRST   = 1'b0;
    idexRST   = 1'b0;
    exmemRST  = 1'b0;
    memwbRST  = 1'b0;
    halted    = 1'b0;
    state_nxt = RUN;
    if (state == HALT) begin
      pcW = 1'b0; ifidW = 1'b0; idexW = 1'b0; exmemW = 1'b0; memwbW = 1'b0;
      halted    = 1'b1;
      state_nxt = HALT;
    end else if (dmem_wait) begin
      // Frozen stages keep any pending branch/halt; MEM/WB gets a bubble.
      pcW = 1'b0; ifidW = 1'b0; idexW = 1'b0; exmemW = 1'b0;
      memwbRST  = 1'b1;
      state_nxt = state;
    end else if (memHALT) begin
      pcW = 1'b0; ifidW = 1'b0; idexW = 1'b0; exmemW = 1'b0;
      state_nxt = HALT;
    end else if (brTaken) begin
      ifidRST = 1'b1;
      idexRST = 1'b1;
    end else if (ld_use) begin
      pcW       = 1'b0;
      ifidW     = 1'b0;
      idexRST   = 1'b1;
      state_nxt = LDSTALL;
    end else if (!ihit) begin
      pcW     = 1'b0;
      ifidRST = 1'b1;
    end
    if (!nRST) begin
      pcW = 1'b0; ifidW = 1'b0; idexW = 1'b0; exmemW = 1'b0; memwbW = 1'b0;
      ifidRST = 1'b0; idexRST = 1'b0; exmemRST = 1'b0; memwbRST = 1'b0;
      halted    = 1'b0;
      state_nxt = RUN;
    end
  end

`ifdef HAZARD_PERF_EN
  logic ld_inc, mem_inc, flush_inc;

  assign mem_inc   = (state != HALT) && dmem_wait;
  assign flush_inc = (state != HALT) && !dmem_wait && !memHALT && brTaken;
  assign ld_inc    = (state != HALT) && !dmem_wait && !memHALT && !brTaken && ld_use;

  hazard_perf u_perf (
    .CLK       (CLK),
    .nRST      (nRST),
    .ld_inc    (ld_inc),
    .mem_inc   (mem_inc),
    .flush_inc (flush_inc),
    .ld_cnt    (ldStallCnt),
    .mem_cnt   (memStallCnt),
    .flush_cnt (flushCnt)
  );
`else
  assign ldStallCnt  = '0;
  assign memStallCnt = '0;
  assign flushCnt    = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vector table, halt/reset
// sequences, then randomized traffic against a rule-level reference model.
module tb_hazard_ctrl;

  typedef struct packed {
    logic       rst;
    logic       ihit;
    logic       dhit;
    logic       memREQ;
    logic       memHALT;
    logic       brTaken;
    logic       exMemRead;
    logic [4:0] exrt;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } in_t;

  typedef struct packed {
    in_t        i;
    logic [9:0] exp;
  } vec_t;

  // {pcW, ifidW, idexW, exmemW, memwbW, ifidRST, idexRST, exmemRST, memwbRST, halted}
  localparam logic [9:0] ZERO_V  = 10'b00000_0000_0;
  localparam logic [9:0] ADV_V   = 10'b11111_0000_0;
  localparam logic [9:0] HALT_V  = 10'b00000_0000_1;
  localparam logic [9:0] DMEM_V  = 10'b00001_0001_0;
  localparam logic [9:0] MHALT_V = 10'b00001_0000_0;
  localparam logic [9:0] BR_V    = 10'b11111_1100_0;
  localparam logic [9:0] LDUSE_V = 10'b00111_0100_0;
  localparam logic [9:0] NOIF_V  = 10'b01111_1000_0;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        ihit = 1'b0, dhit = 1'b0, memREQ = 1'b0, memHALT = 1'b0;
  logic        brTaken = 1'b0, exMemRead = 1'b0;
  logic [4:0]  exrt = '0, idrsel1 = '0, idrsel2 = '0;
  logic        pcW, ifidW, ifidRST, idexW, idexRST, exmemW, exmemRST;
  logic        memwbW, memwbRST, halted;
  logic [31:0] ldStallCnt, memStallCnt, flushCnt;
  logic [9:0]  ctl;

  hazard_ctrl dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .memREQ(memREQ),
    .memHALT(memHALT), .brTaken(brTaken), .exMemRead(exMemRead), .exrt(exrt),
    .idrsel1(idrsel1), .idrsel2(idrsel2), .pcW(pcW), .ifidW(ifidW),
    .ifidRST(ifidRST), .idexW(idexW), .idexRST(idexRST), .exmemW(exmemW),
    .exmemRST(exmemRST), .memwbW(memwbW), .memwbRST(memwbRST), .halted(halted),
    .ldStallCnt(ldStallCnt), .memStallCnt(memStallCnt), .flushCnt(flushCnt)
  );

  assign ctl = {pcW, ifidW, idexW, exmemW, memwbW, ifidRST, idexRST, exmemRST,
                memwbRST, halted};

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  // Reference model: halted flag, one-shot bubble mask, plain event counts.
  bit     m_halted = 1'b0;
  bit     m_masked = 1'b0;
  longint m_ld = 0, m_mem = 0, m_flush = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // 0 reset, 1 halted, 2 dmem wait, 3 memHALT, 4 branch, 5 load-use, 6 no ihit, 7 advance
  function automatic int classify(input in_t i);
    if (!i.rst) return 0;
    if (m_halted) return 1;
    if (i.memREQ && !i.dhit) return 2;
    if (i.memHALT) return 3;
    if (i.brTaken) return 4;
    if (!m_masked && i.exMemRead && i.exrt != 5'd0 &&
        (i.exrt == i.rs1 || i.exrt == i.rs2)) return 5;
    if (!i.ihit) return 6;
    return 7;
  endfunction

  function automatic logic [9:0] model_ctl(input int c);
    case (c)
      0: return ZERO_V;
      1: return HALT_V;
      2: return DMEM_V;
      3: return MHALT_V;
      4: return BR_V;
      5: return LDUSE_V;
      6: return NOIF_V;
      default: return ADV_V;
    endcase
  endfunction

  function automatic longint sat(input longint v);
    return (v >= 64'h0000_0000_FFFF_FFFF) ? 64'h0000_0000_FFFF_FFFF : v + 1;
  endfunction

  function automatic logic [31:0] exp_cnt(input longint v);
`ifdef HAZARD_PERF_EN
    return v[31:0];
`else
    return (v > 0) ? 32'h0 : 32'h0;
`endif
  endfunction

  task automatic model_reset();
    m_halted = 1'b0; m_masked = 1'b0;
    m_ld = 0; m_mem = 0; m_flush = 0;
  endtask

  task automatic model_step(input int c);
    case (c)
      2: m_mem = sat(m_mem);
      3: begin m_halted = 1'b1; m_masked = 1'b0; end
      4: begin m_flush = sat(m_flush); m_masked = 1'b0; end
      5: begin m_ld = sat(m_ld); m_masked = 1'b1; end
      6, 7: m_masked = 1'b0;
      default: ;
    endcase
  endtask

  task automatic check_cnts(input string nm);
    chk({nm, ".ldStallCnt"},  ldStallCnt,  exp_cnt(m_ld));
    chk({nm, ".memStallCnt"}, memStallCnt, exp_cnt(m_mem));
    chk({nm, ".flushCnt"},    flushCnt,    exp_cnt(m_flush));
  endtask

  // Drive on the falling edge, check combinational outputs 2 ns later,
  // advance the model on the rising edge that the DUT also samples.
  task automatic cycle(input in_t i, input logic [9:0] exp, input string nm);
    int c;
    @(negedge CLK);
    nRST = i.rst; ihit = i.ihit; dhit = i.dhit; memREQ = i.memREQ;
    memHALT = i.memHALT; brTaken = i.brTaken; exMemRead = i.exMemRead;
    exrt = i.exrt; idrsel1 = i.rs1; idrsel2 = i.rs2;
    if (!i.rst) model_reset();
    c = classify(i);
    #2;
    chk({nm, ".ctl"}, {22'd0, ctl}, {22'd0, exp});
    check_cnts(nm);
    @(posedge CLK);
    if (i.rst) model_step(c);
  endtask

  function automatic in_t mk(input logic r, input logic ih, input logic dh,
                             input logic mr, input logic mh, input logic br,
                             input logic lr, input int xr, input int s1, input int s2);
    in_t t;
    t.rst = r; t.ihit = ih; t.dhit = dh; t.memREQ = mr; t.memHALT = mh;
    t.brTaken = br; t.exMemRead = lr;
    t.exrt = 5'(xr); t.rs1 = 5'(s1); t.rs2 = 5'(s2);
    return t;
  endfunction

  vec_t tbl[$];

  initial begin
    in_t ri;
    //                rst ih dh mr mh br lr xr s1 s2
    tbl.push_back('{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ZERO_V});   // in reset
    tbl.push_back('{mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0), ADV_V});
    tbl.push_back('{mk(1, 1, 1, 0, 0, 0, 1, 5, 5, 7), LDUSE_V});  // bubble
    tbl.push_back('{mk(1, 1, 1, 0, 0, 0, 1, 5, 5, 7), ADV_V});    // masked once
    tbl.push_back('{mk(1, 1, 1, 0, 0, 0, 1, 0, 3, 0), ADV_V});    // r0 never stalls
    tbl.push_back('{mk(1, 1, 1, 0, 0, 0, 1, 9, 2, 9), LDUSE_V});  // via rs2
    tbl.push_back('{mk(1, 1, 1, 0, 0, 0, 0, 9, 2, 9), ADV_V});    // no load, no stall
    tbl.push_back('{mk(1, 0, 1, 0, 0, 1, 0, 0, 0, 0), BR_V});     // branch beats !ihit
    tbl.push_back('{mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0), NOIF_V});
    tbl.push_back('{mk(1, 1, 0, 1, 0, 1, 0, 0, 0, 0), DMEM_V});   // dmem freeze x3
    tbl.push_back('{mk(1, 1, 0, 1, 0, 1, 0, 0, 0, 0), DMEM_V});
    tbl.push_back('{mk(1, 1, 0, 1, 0, 1, 0, 0, 0, 0), DMEM_V});
    tbl.push_back('{mk(1, 1, 1, 1, 0, 1, 0, 0, 0, 0), BR_V});     // flush on dhit
    tbl.push_back('{mk(1, 1, 1, 0, 0, 0, 1, 4, 4, 4), LDUSE_V});
    tbl.push_back('{mk(1, 1, 0, 1, 0, 0, 1, 4, 4, 4), DMEM_V});   // freeze holds LDSTALL
    tbl.push_back('{mk(1, 1, 1, 0, 0, 0, 1, 4, 4, 4), ADV_V});    // still masked
    tbl.push_back('{mk(1, 1, 1, 0, 0, 0, 1, 4, 4, 4), LDUSE_V});  // back in RUN
    tbl.push_back('{mk(1, 1, 0, 1, 1, 0, 0, 0, 0, 0), DMEM_V});   // halt held by freeze
    tbl.push_back('{mk(1, 1, 1, 0, 1, 1, 0, 0, 0, 0), MHALT_V});  // halt beats branch

    for (int k = 0; k < tbl.size(); k++)
      cycle(tbl[k].i, tbl[k].exp, $sformatf("vec%0d", k));

    for (int k = 0; k < 10; k++)
      cycle(mk(1, k[0], k[1], k[2], 1'b0, ~k[0], 1'b1, 3, 3, 3), HALT_V,
            $sformatf("halt_hold%0d", k));

`ifdef HAZARD_PERF_EN
    chk("cnt_total.ld",    ldStallCnt,  32'd4);
    chk("cnt_total.mem",   memStallCnt, 32'd5);
    chk("cnt_total.flush", flushCnt,    32'd2);
`else
    chk("cnt_total.ld",    ldStallCnt,  32'd0);
    chk("cnt_total.mem",   memStallCnt, 32'd0);
    chk("cnt_total.flush", flushCnt,    32'd0);
`endif

    // Asynchronous reset out of HALT, mid-cycle.
    @(negedge CLK);
    #3 nRST = 1'b0;
    #1;
    model_reset();
    chk("async_rst.ctl", {22'd0, ctl}, {22'd0, ZERO_V});
    check_cnts("async_rst");
    cycle(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0), ADV_V, "post_rst");
    cycle(mk(1, 1, 1, 0, 0, 0, 1, 6, 6, 0), LDUSE_V, "post_rst_lduse");

    // Asynchronous reset mid-bubble.
    @(negedge CLK);
    #3 nRST = 1'b0;
    #1;
    model_reset();
    chk("rst_in_ldstall.ctl", {22'd0, ctl}, {22'd0, ZERO_V});
    cycle(mk(1, 1, 1, 0, 0, 0, 1, 6, 6, 0), LDUSE_V, "rst_in_ldstall_rerun");

    for (int n = 0; n < 3000; n++) begin
      ri.rst       = ($urandom_range(0, 59) != 0);
      ri.ihit      = ($urandom_range(0, 3) != 0);
      ri.dhit      = $urandom_range(0, 1) != 0;
      ri.memREQ    = $urandom_range(0, 1) != 0;
      ri.memHALT   = ($urandom_range(0, 39) == 0);
      ri.brTaken   = ($urandom_range(0, 4) == 0);
      ri.exMemRead = $urandom_range(0, 1) != 0;
      ri.exrt      = 5'($urandom_range(0, 3));
      ri.rs1       = 5'($urandom_range(0, 3));
      ri.rs2       = 5'($urandom_range(0, 3));
      if (!ri.rst) model_reset();
      cycle(ri, model_ctl(classify(ri)), $sformatf("rand%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

- Pipeline hazard controller that drives the write-enable and flush inputs of the PC and all four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Handles four hazard sources: load-use bubbles, taken-branch/jump flushes, instruction- and data-memory wait freezes, and halt drain.
- Holds a small FSM so that a load-use bubble is inserted exactly once and a halt becomes a terminal freeze.

## Interface
Parameters: none.

Clocking: one clock, CLK; reset nRST is asynchronous and active-low.

- CLK  in  1  system clock, rising edge
- nRST  in  1  asynchronous active-low reset
- ihit  in  1  instruction fetch complete this cycle
- dhit  in  1  data access complete this cycle
- memREQ  in  1  MEM stage holds a load or store (dREN|dWEN)
- memHALT  in  1  halt instruction is in MEM
- brTaken  in  1  branch/jump resolved taken in EX
- exMemRead  in  1  EX stage instruction is a load
- exrt  in  5  load destination register in EX
- idrsel1, idrsel2  in  5 each  source registers of the instruction in ID
- pcW  out  1  PC write enable
- ifidW / ifidRST  out  1 each  IF/ID write / flush
- idexW / idexRST  out  1 each  ID/EX write / flush (feed idW / idRST)
- exmemW / exmemRST  out  1 each  EX/MEM write / flush
- memwbW / memwbRST  out  1 each  MEM/WB write / flush
- halted  out  1  core halted
- ldStallCnt, memStallCnt, flushCnt  out  32 each  performance counters

## Operation
FSM states: RUN, LDSTALL, HALT. Reset state is RUN.

Each cycle the first matching case below applies. "Advance" means all W=1 and all RST=0; only the listed signals differ.

1. State HALT: all W=0, all RST=0, halted=1. Stays in HALT until nRST.
2. Dmem wait (memREQ && !dhit):
   - pcW=ifidW=idexW=exmemW=0, memwbRST=1.
   - State unchanged; brTaken and memHALT are held by the frozen stages.
3. memHALT:
   - memwbW=1; all other W=0, all RST=0.
   - Next state HALT.
4. brTaken:
   - Advance, except ifidRST=1 and idexRST=1.
   - pcW=1 regardless of ihit (the wrong-path fetch is abandoned).
   - Next state RUN.
5. Load-use (state RUN only): exMemRead && exrt!=0 && (exrt==idrsel1 || exrt==idrsel2).
   - pcW=0, ifidW=0, idexRST=1; EX/MEM and MEM/WB advance.
   - Next state LDSTALL.
6. !ihit:
   - pcW=0, ifidRST=1; the rest advance.
   - Next state RUN.
7. Otherwise: advance; next state RUN.

LDSTALL: load-use detection is masked for that one cycle; all other rules apply. Next state is RUN unless a dmem wait holds the state.

## Timing
- Control outputs are combinational from the state register and the current inputs; they are sampled by the pipeline registers at the same edge.
- Load-use costs exactly 1 bubble. A taken branch costs 2 squashed slots. Dmem wait costs 1 frozen cycle per cycle that dhit is low.
- While nRST=0: every W and RST output is 0, halted=0, counters are 0, state is RUN.
- Reset asserted mid-stall or in HALT returns the controller to RUN asynchronously.
- Counters increment on the clock edge:
  - ldStallCnt on each cycle case 5 fires.
  - memStallCnt on each case-2 cycle.
  - flushCnt on each case-4 cycle.
  - All three saturate at 32'hFFFFFFFF; none increment in HALT.

## Configuration
- HAZARD_PERF_EN defined: the counter bank is built and behaves as described under Timing.
- HAZARD_PERF_EN undefined: the counter ports remain but are tied to 32'h0, and no counter flops exist.
- Hazard behaviour is identical in both builds.

## Structure
- cpu_types_pkg gains hazstate_t (enum RUN, LDSTALL, HALT) and reuses regbits_t and word_t.
- One sub-module, hazard_perf: three saturating word_t counters with increment strobes. It is instantiated only under HAZARD_PERF_EN.

## Test plan
- Load-use: exMemRead=1, exrt=5, idrsel1=5 → cycle 1: pcW=0, ifidW=0, idexRST=1. Cycle 2 (LDSTALL, same inputs): advance. ldStallCnt=1.
- exrt=0, exMemRead=1, idrsel2=0 → no stall; all W=1.
- Branch during ihit=0: brTaken=1, ihit=0 → pcW=1, ifidRST=1, idexRST=1. flushCnt=1.
- Dmem miss: memREQ=1, dhit=0 for 3 cycles with brTaken=1 → 3 cycles of freeze with memwbRST=1, then the flush fires on the cycle dhit=1. memStallCnt=3.
- Halt: memHALT=1 → memwbW=1 only. Next cycle halted=1 and all W=0, holding for 10 cycles despite ihit/brTaken toggling. nRST pulse → RUN, halted=0.
- Build without HAZARD_PERF_EN, rerun the scenarios → identical control outputs; counters read 0.
